frame_select_sequencer: RTL and testbench



---
 rtl/frame_select_sequencer.sv | 155 +++++++++++++++
 tb/tb_frame_select_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_select_sequencer.sv
// Registered frame-strobe sequencer for NumCols fabric columns from ColBase.
// Ports: CLK/reset, FrameStrobe/FrameReady handshake, FrameSelect,
//   FrameStrobe_I in; FrameStrobe_O slices, Busy, sticky Miss (MissClear).
module frame_select_sequencer #(
  parameter int MaxFramesPerCol  = 20,
  parameter int FrameSelectWidth = 5,
  parameter int NumCols          = 14,
  parameter int ColBase          = 0,
  parameter int StrobeCycles     = 2,
  parameter int GapCycles        = 1
) (
  input  logic                                CLK,
  input  logic                                reset,
  input  logic                                FrameStrobe,
  output logic                                FrameReady,
  input  logic [FrameSelectWidth-1:0]         FrameSelect,
  input  logic [MaxFramesPerCol-1:0]          FrameStrobe_I,
  output logic [NumCols*MaxFramesPerCol-1:0]  FrameStrobe_O,
  output logic                                Busy,
  output logic                                Miss,
  input  logic                                MissClear
);

  localparam int OW   = NumCols * MaxFramesPerCol;
  localparam int CMAX = (StrobeCycles > GapCycles) ? StrobeCycles : GapCycles;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] S_LD = CW'(StrobeCycles - 1);
  localparam logic [CW-1:0] G_LD = CW'((GapCycles > 0) ? GapCycles - 1 : 0);
  localparam logic [FrameSelectWidth-1:0] BCAST = '1;

  if (StrobeCycles < 1 || NumCols < 1 ||
      ColBase + NumCols > (1 << FrameSelectWidth) - 1) begin : g_bad_param
    $fatal(1, "frame_select_sequencer: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_GAP
  } state_t;

  state_t                      r_state, w_state_n;
  logic                        r_ready, w_ready_n;
  logic                        r_miss, w_miss_n;
  logic [CW-1:0]               r_cnt, w_cnt_n;
  logic [OW-1:0]               r_out, w_out_n;
  logic [FrameSelectWidth-1:0] r_sel, w_sel_n;
  logic [MaxFramesPerCol-1:0]  r_vec, w_vec_n;

  logic        w_xfer;
  logic        w_hit;
  logic [31:0] w_off;

  // Expand a select/vector pair into the full slice bus.
  function automatic logic [OW-1:0] f_decode(
    input logic [FrameSelectWidth-1:0] sel,
    input logic [MaxFramesPerCol-1:0]  vec
  );
    logic [OW-1:0] o;
    logic [31:0]   s;
    o = '0;
    s = 32'(sel);
    for (int k = 0; k < NumCols; k++) begin
      if (sel == BCAST || s == 32'(ColBase + k))
        o[k*MaxFramesPerCol +: MaxFramesPerCol] = vec;
    end
    return o;
  endfunction

  assign w_xfer = FrameStrobe && r_ready;
  // Unsigned wrap makes selects below ColBase fail the upper-bound test.
  assign w_off  = 32'(FrameSelect) - 32'(ColBase);
  assign w_hit  = (FrameSelect == BCAST) || (w_off < 32'(NumCols));

  always_comb begin
    w_state_n = r_state;
    w_ready_n = r_ready;
    w_cnt_n   = r_cnt;
    w_out_n   = r_out;
    w_sel_n   = r_sel;
    w_vec_n   = r_vec;
    w_miss_n  = MissClear ? 1'b0 : r_miss;
    unique case (r_state)
      S_IDLE: begin
        w_ready_n = 1'b1;
        if (w_xfer) begin
          w_sel_n = FrameSelect;
          w_vec_n = FrameStrobe_I;
          if (!w_hit) begin
            w_miss_n = 1'b1;
          end else if (FrameStrobe_I != '0) begin
            w_state_n = S_STROBE;
            w_out_n   = f_decode(FrameSelect, FrameStrobe_I);
            w_cnt_n   = S_LD;
            w_ready_n = 1'b0;
          end
        end
      end
      S_STROBE: begin
        if (r_cnt == '0) begin
          w_out_n = '0;
          if (GapCycles == 0) begin
            w_state_n = S_IDLE;
            w_ready_n = 1'b1;
          end else begin
            w_state_n = S_GAP;
            w_cnt_n   = G_LD;
          end
        end else begin
          w_cnt_n = r_cnt - 1'b1;
          w_out_n = f_decode(r_sel, r_vec);
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          w_state_n = S_IDLE;
          w_ready_n = 1'b1;
        end else begin
          w_cnt_n = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_out_n   = '0;
        w_ready_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_miss  <= 1'b0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_sel   <= '0;
      r_vec   <= '0;
    end else begin
      r_state <= w_state_n;
      r_ready <= w_ready_n;
      r_miss  <= w_miss_n;
      r_cnt   <= w_cnt_n;
      r_out   <= w_out_n;
      r_sel   <= w_sel_n;
      r_vec   <= w_vec_n;
    end
  end

  assign FrameReady    = r_ready;
  assign FrameStrobe_O = r_out;
  assign Busy          = (r_state != S_IDLE);
  assign Miss          = r_miss;

endmodule

// File: tb/tb_frame_select_sequencer.sv
// Scoreboard bench for frame_select_sequencer: default instance plus a
// narrow instance (4 cols at base 8, 1-cycle strobe, no gap).
module tb_frame_select_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         a_fs, a_ready, a_busy, a_miss, a_mclr;
  logic [4:0]   a_sel;
  logic [19:0]  a_vec;
  logic [279:0] a_out;

  logic         b_fs, b_ready, b_busy, b_miss, b_mclr;
  logic [4:0]   b_sel;
  logic [19:0]  b_vec;
  logic [79:0]  b_out;

  frame_select_sequencer u_a (
    .CLK(clk), .reset(rst),
    .FrameStrobe(a_fs), .FrameReady(a_ready),
    .FrameSelect(a_sel), .FrameStrobe_I(a_vec),
    .FrameStrobe_O(a_out), .Busy(a_busy),
    .Miss(a_miss), .MissClear(a_mclr)
  );

  frame_select_sequencer #(
    .NumCols(4), .ColBase(8), .StrobeCycles(1), .GapCycles(0)
  ) u_b (
    .CLK(clk), .reset(rst),
    .FrameStrobe(b_fs), .FrameReady(b_ready),
    .FrameSelect(b_sel), .FrameStrobe_I(b_vec),
    .FrameStrobe_O(b_out), .Busy(b_busy),
    .Miss(b_miss), .MissClear(b_mclr)
  );

  int checks = 0;
  int errors = 0;

  logic [279:0] qa[$];
  logic [79:0]  qb[$];

  task automatic chk(string nm, logic [279:0] act, logic [279:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [279:0] ea(int sel, logic [19:0] v);
    logic [279:0] o;
    o = '0;
    if (sel == 31) begin
      for (int k = 0; k < 14; k++) o[k*20 +: 20] = v;
    end else begin
      o[sel*20 +: 20] = v;
    end
    return o;
  endfunction

  function automatic logic [79:0] eb(int slice, logic [19:0] v);
    logic [79:0] o;
    o = '0;
    o[slice*20 +: 20] = v;
    return o;
  endfunction

  // Monitors: every non-zero strobe cycle must match the next expected entry.
  always @(negedge clk) begin
    if (a_out !== '0) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_strobe: got %0h expected none", a_out);
      end else begin
        logic [279:0] e;
        e = qa.pop_front();
        if (a_out !== e) begin
          errors++;
          $display("FAIL a_strobe: got %0h expected %0h", a_out, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_out !== '0) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_strobe: got %0h expected none", b_out);
      end else begin
        logic [79:0] e;
        e = qb.pop_front();
        if (b_out !== e) begin
          errors++;
          $display("FAIL b_strobe: got %0h expected %0h", b_out, e);
        end
      end
    end
  end

  task automatic send_a(int sel, logic [19:0] v, int n);
    a_fs  = 1'b1;
    a_sel = 5'(sel);
    a_vec = v;
    repeat (n) qa.push_back(ea(sel, v));
    @(negedge clk);
    a_fs = 1'b0;
  endtask

  task automatic send_b(int sel, int slice, logic [19:0] v, int n);
    b_fs  = 1'b1;
    b_sel = 5'(sel);
    b_vec = v;
    repeat (n) qb.push_back(eb(slice, v));
    @(negedge clk);
    b_fs = 1'b0;
  endtask

  task automatic wait_ready_a(string nm, int expn);
    int n;
    n = 0;
    while (a_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n, expn);
  endtask

  int          t4_sel[8] = '{1, 2, 5, 6, 7, 8, 9, 13};
  logic [19:0] t4_vec[8] = '{20'h00003, 20'h11111, 20'h22222, 20'h33333,
                             20'h44444, 20'h00C00, 20'h55555, 20'h66666};

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a_fs = 0; a_sel = 0; a_vec = 0; a_mclr = 0;
    b_fs = 0; b_sel = 0; b_vec = 0; b_mclr = 0;
    #12;
    chk("rst_ready", a_ready, 0);
    chk("rst_out", a_out, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_miss", a_miss, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("ready_before_edge", a_ready, 0);
    @(negedge clk);
    chk("ready_after_edge", a_ready, 1);
    chk("b_ready_after_edge", b_ready, 1);

    // Single column strobe
    send_a(3, 20'h00010, 2);
    chk("t1_busy1", a_busy, 1);
    chk("t1_ready1", a_ready, 0);
    @(negedge clk);
    chk("t1_busy2", a_busy, 1);
    chk("t1_ready2", a_ready, 0);
    @(negedge clk);
    chk("t1_gap_out", a_out, 0);
    chk("t1_gap_busy", a_busy, 1);
    chk("t1_gap_ready", a_ready, 0);
    @(negedge clk);
    chk("t1_ready4", a_ready, 1);
    chk("t1_idle_busy", a_busy, 0);
    chk("t1_q_empty", qa.size(), 0);

    // Broadcast
    send_a(31, 20'h80000, 2);
    wait_ready_a("t2_ready_lat", 3);
    chk("t2_miss", a_miss, 0);
    chk("t2_q_empty", qa.size(), 0);

    // Out of range, then back-to-back accept
    send_a(20, 20'h00001, 0);
    chk("t3_miss_set", a_miss, 1);
    chk("t3_ready_hold", a_ready, 1);
    send_a(0, 20'h00002, 2);
    chk("t3_b2b_busy", a_busy, 1);
    wait_ready_a("t3_ready_lat", 3);
    a_mclr = 1'b1;
    @(negedge clk);
    a_mclr = 1'b0;
    chk("t3_miss_clr", a_miss, 0);
    a_mclr = 1'b1;
    send_a(25, 20'h00004, 0);
    a_mclr = 1'b0;
    chk("t3_miss_set_wins", a_miss, 1);
    send_a(4, 20'h00000, 0);
    chk("t3_noop_miss", a_miss, 1);
    chk("t3_noop_busy", a_busy, 0);
    send_a(31, 20'h00000, 0);
    chk("t3_noop_bc_busy", a_busy, 0);
    chk("t3_noop_bc_ready", a_ready, 1);

    // Valid held high with changing data: one transfer per 4 cycles
    for (int i = 0; i < 8; i++) begin
      chk("t4_ready", a_ready, ((i % 4) == 0) ? 1 : 0);
      a_fs  = 1'b1;
      a_sel = 5'(t4_sel[i]);
      a_vec = t4_vec[i];
      if ((i % 4) == 0) qa.push_back(ea(t4_sel[i], t4_vec[i]));
      if ((i % 4) == 0) qa.push_back(ea(t4_sel[i], t4_vec[i]));
      @(negedge clk);
    end
    a_fs = 1'b0;
    chk("t4_ready_end", a_ready, 1);
    chk("t4_q_empty", qa.size(), 0);

    // Reset in the second strobe cycle
    send_a(6, 20'hABCDE, 2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_out", a_out, 0);
    chk("t5_async_busy", a_busy, 0);
    chk("t5_async_ready", a_ready, 0);
    qa.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_ready_back", a_ready, 1);
    chk("t5_miss_reset", a_miss, 0);
    send_a(2, 20'h00001, 2);
    wait_ready_a("t5_ready_lat", 3);
    chk("t5_q_empty", qa.size(), 0);

    // Narrow instance
    send_b(9, 1, 20'h00042, 1);
    chk("t6_busy", b_busy, 1);
    chk("t6_ready_low", b_ready, 0);
    @(negedge clk);
    chk("t6_ready_next", b_ready, 1);
    chk("t6_idle_busy", b_busy, 0);
    chk("t6_out_clear", b_out, 0);
    send_b(11, 3, 20'hFFFFF, 1);
    @(negedge clk);
    chk("t6_top_ready", b_ready, 1);
    send_b(12, 0, 20'h00001, 0);
    chk("t6_above_miss", b_miss, 1);
    b_mclr = 1'b1;
    @(negedge clk);
    b_mclr = 1'b0;
    chk("t6_miss_clr", b_miss, 0);
    send_b(7, 0, 20'h00001, 0);
    chk("t6_below_miss", b_miss, 1);
    send_b(10, 2, 20'h00000, 0);
    chk("t6_noop_miss", b_miss, 1);
    chk("t6_noop_busy", b_busy, 0);
    chk("t6_noop_ready", b_ready, 1);
    @(negedge clk);
    chk("t6_q_empty", qb.size(), 0);
    chk("final_qa_empty", qa.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
